fcore_fetch_decode: RTL and testbench

- Instruction fetch and decode front end for the fCore.
- Sequences the program memory from address 0 on a start pulse, splits each word into opcode and register fields, and merges the constant word that follows LDC into a single decoded instruction.
- Handles STOP, the EFI stall handshake, and reserved opcodes (27-31).
- Feeds the fCore execution pipeline that consumes the 5-bit fcore_operations encoding.

---
 rtl/fcore_fetch_decode.sv | 210 +++++++++++++++++++++
 tb/tb_fcore_fetch_decode.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fcore_fetch_decode.sv
// fCore instruction fetch/decode front end: sequences program memory from address 0,
// splits words into opcode/register fields, merges LDC constants, handles STOP/EFI/reserved.
module fcore_fetch_decode #(
  parameter int PMEM_ADDR_WIDTH   = 10,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int OPCODE_WIDTH      = 5,
  parameter int REG_ADDR_WIDTH    = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic                         pmem_en,
  output logic [PMEM_ADDR_WIDTH-1:0]   pmem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] pmem_data,
  input  logic                         efi_done,
  output logic                         instr_valid,
  output logic [OPCODE_WIDTH-1:0]      opcode,
  output logic [REG_ADDR_WIDTH-1:0]    operand_a,
  output logic [REG_ADDR_WIDTH-1:0]    operand_b,
  output logic [REG_ADDR_WIDTH-1:0]    dest,
  output logic [INSTRUCTION_WIDTH-1:0] immediate,
  output logic                         busy,
  output logic                         done,
  output logic                         illegal_opcode,
  output logic                         overrun
);

  typedef enum logic [1:0] {IDLE, RUN, CONST, EFI_WAIT} state_t;

  localparam logic [OPCODE_WIDTH-1:0]    OP_LDC    = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0]    OP_STOP   = OPCODE_WIDTH'(12);
  localparam logic [OPCODE_WIDTH-1:0]    OP_EFI    = OPCODE_WIDTH'(21);
  localparam logic [OPCODE_WIDTH-1:0]    OP_RSV_LO = OPCODE_WIDTH'(27);
  localparam logic [PMEM_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                       state, state_n;
  logic [PMEM_ADDR_WIDTH-1:0]   pc, pc_n;
  logic                         inflight, inflight_n;
  logic                         inflight_last, inflight_last_n;
  logic                         fetch_stop, fetch_stop_n;
  logic                         ending, ending_n;
  logic [REG_ADDR_WIDTH-1:0]    ldc_a, ldc_a_n, ldc_b, ldc_b_n, ldc_dest, ldc_dest_n;
  logic                         valid_n, done_n, illegal_n, overrun_n;
  logic [OPCODE_WIDTH-1:0]      opcode_n;
  logic [REG_ADDR_WIDTH-1:0]    operand_a_n, operand_b_n, dest_n;
  logic [INSTRUCTION_WIDTH-1:0] immediate_n;
  logic                         fetch, cancel;

  logic [OPCODE_WIDTH-1:0]   w_op;
  logic [REG_ADDR_WIDTH-1:0] w_a, w_b, w_dest;

  assign w_op   = pmem_data[OPCODE_WIDTH-1:0];
  assign w_a    = pmem_data[OPCODE_WIDTH +: REG_ADDR_WIDTH];
  assign w_b    = pmem_data[OPCODE_WIDTH + REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
  assign w_dest = pmem_data[OPCODE_WIDTH + 2*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];

  assign fetch     = (state == RUN || state == CONST) && !ending && !fetch_stop;
  assign pmem_en   = fetch;
  assign pmem_addr = pc;
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      pc             <= '0;
      inflight       <= 1'b0;
      inflight_last  <= 1'b0;
      fetch_stop     <= 1'b0;
      ending         <= 1'b0;
      ldc_a          <= '0;
      ldc_b          <= '0;
      ldc_dest       <= '0;
      instr_valid    <= 1'b0;
      opcode         <= '0;
      operand_a      <= '0;
      operand_b      <= '0;
      dest           <= '0;
      immediate      <= '0;
      done           <= 1'b0;
      illegal_opcode <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      inflight       <= inflight_n;
      inflight_last  <= inflight_last_n;
      fetch_stop     <= fetch_stop_n;
      ending         <= ending_n;
      ldc_a          <= ldc_a_n;
      ldc_b          <= ldc_b_n;
      ldc_dest       <= ldc_dest_n;
      instr_valid    <= valid_n;
      opcode         <= opcode_n;
      operand_a      <= operand_a_n;
      operand_b      <= operand_b_n;
      dest           <= dest_n;
      immediate      <= immediate_n;
      done           <= done_n;
      illegal_opcode <= illegal_n;
      overrun        <= overrun_n;
    end
  end

  always_comb begin
    state_n         = state;
    pc_n            = pc;
    inflight_n      = 1'b0;
    inflight_last_n = 1'b0;
    fetch_stop_n    = fetch_stop;
    ending_n        = 1'b0;
    ldc_a_n         = ldc_a;
    ldc_b_n         = ldc_b;
    ldc_dest_n      = ldc_dest;
    valid_n         = 1'b0;
    opcode_n        = opcode;
    operand_a_n     = operand_a;
    operand_b_n     = operand_b;
    dest_n          = dest;
    immediate_n     = immediate;
    done_n          = 1'b0;
    illegal_n       = illegal_opcode;
    overrun_n       = overrun;
    cancel          = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n      = RUN;
          pc_n         = '0;
          fetch_stop_n = 1'b0;
          illegal_n    = 1'b0;
          overrun_n    = 1'b0;
        end
      end
      RUN: begin
        // 'ending' is the extra cycle between the terminating word and the done pulse
        if (ending) begin
          state_n      = IDLE;
          done_n       = 1'b1;
          pc_n         = '0;
          fetch_stop_n = 1'b0;
        end else if (inflight) begin
          if (w_op == OP_STOP) begin
            cancel   = 1'b1;
            ending_n = 1'b1;
          end else begin
            if (w_op == OP_LDC) begin
              ldc_a_n    = w_a;
              ldc_b_n    = w_b;
              ldc_dest_n = w_dest;
              state_n    = CONST;
            end else begin
              valid_n     = 1'b1;
              immediate_n = '0;
              if (w_op >= OP_RSV_LO) begin
                opcode_n    = '0;
                operand_a_n = '0;
                operand_b_n = '0;
                dest_n      = '0;
                illegal_n   = 1'b1;
              end else begin
                opcode_n    = w_op;
                operand_a_n = w_a;
                operand_b_n = w_b;
                dest_n      = w_dest;
              end
              if (w_op == OP_EFI && !inflight_last) begin
                state_n = EFI_WAIT;
                cancel  = 1'b1;
              end
            end
            if (inflight_last) begin
              state_n   = RUN;
              overrun_n = 1'b1;
              ending_n  = 1'b1;
            end
          end
        end
      end
      CONST: begin
        if (inflight) begin
          valid_n     = 1'b1;
          opcode_n    = OP_LDC;
          operand_a_n = ldc_a;
          operand_b_n = ldc_b;
          dest_n      = ldc_dest;
          immediate_n = pmem_data;
          state_n     = RUN;
          if (inflight_last) begin
            overrun_n = 1'b1;
            ending_n  = 1'b1;
          end
        end
      end
      EFI_WAIT: begin
        if (efi_done) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase

    // A cancelled read leaves pc pointing at the cancelled address so fetch resumes there
    if (fetch && !cancel) begin
      inflight_n      = 1'b1;
      inflight_last_n = (pc == LAST_ADDR);
      if (pc == LAST_ADDR) fetch_stop_n = 1'b1;
      else                 pc_n         = pc + 1'b1;
    end
  end

endmodule

// File: tb/tb_fcore_fetch_decode.sv
// Scoreboard bench for fcore_fetch_decode: a program-level reference model predicts every
// emitted instruction (with its cycle), the EFI release schedule, done timing and sticky flags.
module tb_fcore_fetch_decode;
  localparam int AW = 4;
  localparam int IW = 32;
  localparam int OW = 5;
  localparam int RW = 4;

  logic          clock = 1'b0, reset = 1'b1, start = 1'b0, efi_done = 1'b0;
  logic          pmem_en, instr_valid, busy, done, illegal_opcode, overrun;
  logic [AW-1:0] pmem_addr;
  logic [IW-1:0] pmem_data = '0, immediate;
  logic [OW-1:0] opcode;
  logic [RW-1:0] operand_a, operand_b, dest;

  fcore_fetch_decode #(.PMEM_ADDR_WIDTH(AW), .INSTRUCTION_WIDTH(IW),
                       .OPCODE_WIDTH(OW), .REG_ADDR_WIDTH(RW)) dut (
    .clock(clock), .reset(reset), .start(start), .pmem_en(pmem_en), .pmem_addr(pmem_addr),
    .pmem_data(pmem_data), .efi_done(efi_done), .instr_valid(instr_valid), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b), .dest(dest), .immediate(immediate),
    .busy(busy), .done(done), .illegal_opcode(illegal_opcode), .overrun(overrun));

  always #5 clock = ~clock;

  logic [IW-1:0] mem [0:15];
  always @(posedge clock) if (pmem_en) pmem_data <= mem[pmem_addr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {int op; int a; int b; int d; logic [31:0] imm; int cyc;} exp_t;
  exp_t exp_q[$];
  int   win_lo[$], win_hi[$];
  bit   efi_at [0:511];
  int   n_vec = 0, n_err = 0;
  int   t0 = 0, done_cnt = 0, done_rel = -1, done_cyc = 0, efi_fixed = 0;
  bit   running = 0, exp_ill = 0, exp_ovr = 0;

  function automatic logic [31:0] mk(int op, int a, int b, int d);
    return {15'b0, d[3:0], b[3:0], a[3:0], op[4:0]};
  endfunction

  task automatic check(string name, longint act, longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Walks the program as the ISA describes it; off = cycles lost to EFI stalls so far
  task automatic build_model();
    int i = 0, off = 0, op, t, dly;
    logic [31:0] w;
    exp_q.delete(); win_lo.delete(); win_hi.delete();
    foreach (efi_at[k]) efi_at[k] = 0;
    exp_ill = 0; exp_ovr = 0; done_cyc = -1;
    for (int step = 0; step < 40; step++) begin
      w  = mem[i];
      op = int'(w[4:0]);
      if (op == 12) begin done_cyc = i + 4 + off; break; end
      if (op == 6) begin
        exp_q.push_back('{6, int'(w[8:5]), int'(w[12:9]), int'(w[16:13]), mem[i+1], i + 4 + off});
        if (i + 1 == 15) begin exp_ovr = 1; done_cyc = i + 5 + off; break; end
        i += 2;
        continue;
      end
      if (op >= 27) begin
        exp_q.push_back('{0, 0, 0, 0, 32'h0, i + 3 + off});
        exp_ill = 1;
      end else begin
        exp_q.push_back('{op, int'(w[8:5]), int'(w[12:9]), int'(w[16:13]), 32'h0, i + 3 + off});
      end
      if (op == 21 && i != 15) begin
        t   = i + 3 + off;
        dly = (efi_fixed != 0) ? efi_fixed : int'($urandom_range(1, 5));
        efi_at[i + 2 + off] = 1;  // same cycle as EFI decode: must be ignored
        efi_at[t + dly]     = 1;
        win_lo.push_back(t);
        win_hi.push_back(t + dly);
        off += dly + 2;
      end
      if (i == 15) begin exp_ovr = 1; done_cyc = 19 + off; break; end
      i++;
    end
  endtask

  initial forever begin
    @(negedge clock);
    if (running && (cyc - t0) >= 0 && (cyc - t0) < 512) efi_done = efi_at[cyc - t0];
    else                                                efi_done = 1'b0;
  end

  // Monitor: pops the scoreboard whenever an instruction is presented
  initial forever begin
    int rel;
    exp_t e;
    @(negedge clock);
    if (running && !reset) begin
      rel = cyc - t0;
      if (rel == 1) check("sticky_clear_on_start", {illegal_opcode, overrun}, 0);
      foreach (win_lo[k])
        if (rel >= win_lo[k] && rel <= win_hi[k]) check("pmem_en_in_efi_wait", pmem_en, 0);
      if (done) begin done_cnt++; done_rel = rel; end
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_instr", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("instr_fields", {opcode, operand_a, operand_b, dest, immediate},
                {e.op[4:0], e.a[3:0], e.b[3:0], e.d[3:0], e.imm});
          check("instr_cycle", rel, e.cyc);
        end
      end
    end
  end

  task automatic run_prog();
    build_model();
    @(negedge clock);
    done_cnt = 0; done_rel = -1;
    t0 = cyc; start = 1'b1; running = 1;
    @(negedge clock);
    start = 1'b0;
    while (done_cnt == 0 && (cyc - t0) < 400) @(negedge clock);
    repeat (3) @(negedge clock);
    check("done_count", done_cnt, 1);
    check("done_cycle", done_rel, done_cyc);
    check("pending_instrs", exp_q.size(), 0);
    check("illegal_opcode", illegal_opcode, exp_ill);
    check("overrun", overrun, exp_ovr);
    check("idle_after_done", {busy, pmem_en, instr_valid}, 0);
    check("pc_reset", pmem_addr, 0);
    running = 0;
  endtask

  task automatic fill_random();
    foreach (mem[k]) mem[k] = $urandom;
  endtask

  initial begin
    int k, op;
    fill_random();
    repeat (2) @(negedge clock);
    check("reset_outputs", {busy, pmem_en, instr_valid, done, illegal_opcode, overrun,
                            opcode, operand_a, operand_b, dest, immediate}, 0);
    reset = 1'b0;
    @(negedge clock);
    check("reset_pc", pmem_addr, 0);

    // ADD r1,r2->r3; MUL; STOP
    fill_random();
    mem[0] = mk(1, 1, 2, 3); mem[1] = mk(3, 4, 5, 6); mem[2] = mk(12, 0, 0, 0);
    run_prog();
    // LDC dest=5; constant; SUB; STOP
    mem[0] = mk(6, 0, 0, 5); mem[1] = 32'h3F80_0000; mem[2] = mk(2, 7, 8, 9); mem[3] = mk(12, 0, 0, 0);
    run_prog();
    // EFI; ADD; STOP with release 4 cycles after EFI emission
    mem[0] = mk(21, 1, 1, 1); mem[1] = mk(1, 2, 3, 4); mem[2] = mk(12, 0, 0, 0);
    efi_fixed = 4;
    run_prog();
    efi_fixed = 0;
    // reserved opcode 29; ADD; STOP
    mem[0] = mk(29, 15, 15, 15); mem[1] = mk(1, 1, 2, 3); mem[2] = mk(12, 0, 0, 0);
    run_prog();
    // no STOP anywhere: overrun at the last address
    foreach (mem[j]) mem[j] = mk(int'($urandom_range(0, 5)) == 0 ? 1 : 2, j % 16, 3, 4);
    run_prog();
    check("overrun_sticky_held", overrun, 1);

    // reset while in CONST aborts with no done, then a clean rerun
    mem[0] = mk(6, 0, 0, 5); mem[1] = 32'h3F80_0000; mem[2] = mk(2, 7, 8, 9); mem[3] = mk(12, 0, 0, 0);
    exp_q.delete(); win_lo.delete(); win_hi.delete();
    foreach (efi_at[j]) efi_at[j] = 0;
    @(negedge clock);
    done_cnt = 0; t0 = cyc; start = 1'b1; running = 1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {busy, pmem_en, instr_valid, done, illegal_opcode, overrun,
                                  opcode, operand_a, operand_b, dest, immediate}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    check("no_done_after_abort", done_cnt, 0);
    running = 0;
    run_prog();

    // randomized programs
    for (int p = 0; p < 24; p++) begin
      fill_random();
      for (int j = 0; j < 16; j++) begin
        op = int'($urandom_range(0, 31));
        if (op == 12) op = 1;
        if (j == 15 && (op == 6 || op == 21)) op = 1;
        mem[j] = (mem[j] & 32'hFFFF_FFE0) | 32'(op);
      end
      k = int'($urandom_range(1, 16));
      if (k < 16) mem[k] = mk(12, 0, 0, 0);
      run_prog();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
